mult_pipeline: RTL and testbench

//  Five-stage fixed-latency integer multiply pipe (M1..M5) beside the EX/MEM path.

---
 rtl/mult_pipeline.sv | 130 +++++++++++++
 tb/tb_mult_pipeline.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mult_pipeline.sv
// -----------------------------------------------------------------------------
// mult_pipeline
//   Five-stage fixed-latency integer multiplier (M1..M5) that sits beside the
//   EX/MEM path. Accepts one MUL per cycle and returns the low DATA_W bits of
//   src1*src2 at M5. It never stalls. Per-stage dst/regwrite are exported so the
//   hazard unit can stall decode.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   id_issue                decode launches a MUL this cycle
//   id_src1_val/id_src2_val forwarded operands A, B
//   id_dst_reg/id_regwrite  destination and write enable
//   kill_m1                 squash the instruction currently in M1
//   mK_dst_reg/mK_regwrite  per-stage destination / live-write flag (K=1..5)
//   wb_valid/wb_dst_reg/wb_data  M5 writeback
//   busy                    any stage holds a valid instruction
// -----------------------------------------------------------------------------
module mult_pipeline #(
   parameter int DATA_W   = 32,
   parameter int REG_ADDR = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                id_issue,
   input  logic [DATA_W-1:0]   id_src1_val,
   input  logic [DATA_W-1:0]   id_src2_val,
   input  logic [REG_ADDR-1:0] id_dst_reg,
   input  logic                id_regwrite,
   input  logic                kill_m1,
   output logic [REG_ADDR-1:0] m1_dst_reg,
   output logic [REG_ADDR-1:0] m2_dst_reg,
   output logic [REG_ADDR-1:0] m3_dst_reg,
   output logic [REG_ADDR-1:0] m4_dst_reg,
   output logic [REG_ADDR-1:0] m5_dst_reg,
   output logic                m1_regwrite,
   output logic                m2_regwrite,
   output logic                m3_regwrite,
   output logic                m4_regwrite,
   output logic                m5_regwrite,
   output logic                wb_valid,
   output logic [REG_ADDR-1:0] wb_dst_reg,
   output logic [DATA_W-1:0]   wb_data,
   output logic                busy
);
   localparam int H      = DATA_W / 2;
   localparam int STAGES = 5;

   // ---------------- control pipe ----------------
   logic [STAGES:1]               vld_q;   // stage valid bits
   logic [STAGES:1]               rw_q;    // regwrite with r0 already masked
   logic [STAGES:1][REG_ADDR-1:0] dst_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         rw_q  <= '0;
         dst_q <= '0;
      end else begin
         vld_q[1] <= id_issue;
         rw_q[1]  <= id_issue & id_regwrite & (id_dst_reg != '0);
         dst_q[1] <= id_issue ? id_dst_reg : '0;
         // only M1 can be flushed; everything past it is older than any flush source
         vld_q[2] <= vld_q[1] & ~kill_m1;
         for (int k = 3; k <= STAGES; k++) vld_q[k] <= vld_q[k-1];
         for (int k = 2; k <= STAGES; k++) begin
            rw_q[k]  <= rw_q[k-1];
            dst_q[k] <= dst_q[k-1];
         end
      end
   end

   // ---------------- datapath ----------------
   // Only the low DATA_W bits are needed, so ah*bh never contributes and the
   // cross terms only matter modulo 2^h.
   logic [DATA_W-1:0] a_q, b_q;
   logic [DATA_W-1:0] pp0_m2_q, pp0_m3_q, res_m4_q, res_m5_q;
   logic [H-1:0]      pp1_q, pp2_q, cross_q;

   logic [DATA_W-1:0] pp0_d, res_d;
   logic [H-1:0]      pp1_d, pp2_d, cross_d;

   always_comb begin
      pp0_d   = DATA_W'(a_q[H-1:0]) * DATA_W'(b_q[H-1:0]);
      pp1_d   = a_q[H-1:0] * b_q[DATA_W-1:H];
      pp2_d   = a_q[DATA_W-1:H] * b_q[H-1:0];
      cross_d = pp1_q + pp2_q;
      res_d   = pp0_m3_q + {cross_q, {H{1'b0}}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         pp0_m2_q <= '0;
         pp1_q    <= '0;
         pp2_q    <= '0;
         pp0_m3_q <= '0;
         cross_q  <= '0;
         res_m4_q <= '0;
         res_m5_q <= '0;
      end else begin
         a_q      <= id_src1_val;
         b_q      <= id_src2_val;
         pp0_m2_q <= pp0_d;
         pp1_q    <= pp1_d;
         pp2_q    <= pp2_d;
         pp0_m3_q <= pp0_m2_q;
         cross_q  <= cross_d;
         res_m4_q <= res_d;
         res_m5_q <= res_m4_q;
      end
   end

   // ---------------- outputs ----------------
   assign m1_dst_reg  = dst_q[1];
   assign m2_dst_reg  = dst_q[2];
   assign m3_dst_reg  = dst_q[3];
   assign m4_dst_reg  = dst_q[4];
   assign m5_dst_reg  = dst_q[5];
   assign m1_regwrite = vld_q[1] & rw_q[1];
   assign m2_regwrite = vld_q[2] & rw_q[2];
   assign m3_regwrite = vld_q[3] & rw_q[3];
   assign m4_regwrite = vld_q[4] & rw_q[4];
   assign m5_regwrite = vld_q[5] & rw_q[5];
   assign wb_valid    = m5_regwrite;
   assign wb_dst_reg  = dst_q[5];
   assign wb_data     = res_m5_q;
   assign busy        = |vld_q;

endmodule

// File: tb/tb_mult_pipeline.sv
// Bench for mult_pipeline: directed scenarios followed by random traffic, all
// compared cycle by cycle against an issue-history model (what was issued in
// which cycle, whether it was killed, where the last reset was).
module tb_mult_pipeline;
   localparam int DW = 32;
   localparam int RA = 5;
   localparam int NC = 1024;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          id_issue = 1'b0;
   logic [DW-1:0] id_src1_val = '0;
   logic [DW-1:0] id_src2_val = '0;
   logic [RA-1:0] id_dst_reg = '0;
   logic          id_regwrite = 1'b0;
   logic          kill_m1 = 1'b0;
   logic [RA-1:0] m1_dst_reg, m2_dst_reg, m3_dst_reg, m4_dst_reg, m5_dst_reg;
   logic          m1_regwrite, m2_regwrite, m3_regwrite, m4_regwrite, m5_regwrite;
   logic          wb_valid, busy;
   logic [RA-1:0] wb_dst_reg;
   logic [DW-1:0] wb_data;

   mult_pipeline #(.DATA_W(DW), .REG_ADDR(RA)) dut (
      .clk(clk), .rst_n(rst_n), .id_issue(id_issue),
      .id_src1_val(id_src1_val), .id_src2_val(id_src2_val),
      .id_dst_reg(id_dst_reg), .id_regwrite(id_regwrite), .kill_m1(kill_m1),
      .m1_dst_reg(m1_dst_reg), .m2_dst_reg(m2_dst_reg), .m3_dst_reg(m3_dst_reg),
      .m4_dst_reg(m4_dst_reg), .m5_dst_reg(m5_dst_reg),
      .m1_regwrite(m1_regwrite), .m2_regwrite(m2_regwrite), .m3_regwrite(m3_regwrite),
      .m4_regwrite(m4_regwrite), .m5_regwrite(m5_regwrite),
      .wb_valid(wb_valid), .wb_dst_reg(wb_dst_reg), .wb_data(wb_data), .busy(busy));

   always #5 clk = ~clk;

   logic [RA-1:0] dst_o [1:5];
   logic [5:1]    rw_o;
   assign dst_o[1] = m1_dst_reg;
   assign dst_o[2] = m2_dst_reg;
   assign dst_o[3] = m3_dst_reg;
   assign dst_o[4] = m4_dst_reg;
   assign dst_o[5] = m5_dst_reg;
   assign rw_o = {m5_regwrite, m4_regwrite, m3_regwrite, m2_regwrite, m1_regwrite};

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int floor_c = 0;   // first cycle whose issues survive the most recent reset

   // issue history, indexed by the cycle the issue was presented
   bit            iv   [NC];
   bit            irw  [NC];
   bit            ik   [NC];
   logic [RA-1:0] idst [NC];
   logic [DW-1:0] ires [NC];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic check_outputs(input bit in_rst);
      bit any_v;
      if (in_rst) begin
         chk("rst_busy", busy, 0);
         chk("rst_wb_valid", wb_valid, 0);
         chk("rst_wb_data", wb_data, 0);
         chk("rst_wb_dst", wb_dst_reg, 0);
         for (int k = 1; k <= 5; k++) begin
            chk($sformatf("rst_m%0d_rw", k), rw_o[k], 0);
            chk($sformatf("rst_m%0d_dst", k), dst_o[k], 0);
         end
         return;
      end
      any_v = 0;
      for (int k = 1; k <= 5; k++) begin
         int  j;
         bit  live, v, e_rw;
         j    = cyc - k;
         live = (j >= floor_c) && iv[j];
         v    = live && !(k >= 2 && ik[j]);
         e_rw = v && irw[j] && (idst[j] != 0);
         any_v |= v;
         chk($sformatf("m%0d_rw", k), rw_o[k], e_rw);
         if (v) chk($sformatf("m%0d_dst", k), dst_o[k], idst[j]);
         if (k == 5) begin
            chk("wb_valid", wb_valid, e_rw);
            if (v) chk("wb_dst", wb_dst_reg, idst[j]);
            if (e_rw) chk("wb_data", wb_data, ires[j]);
         end
      end
      chk("busy", busy, any_v);
   endtask

   task automatic step(input bit iss, input logic [RA-1:0] d, input bit rw,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input bit kill, input bit rst);
      id_issue    = iss;
      id_dst_reg  = d;
      id_regwrite = rw;
      id_src1_val = a;
      id_src2_val = b;
      kill_m1     = kill;
      rst_n       = !rst;
      iv[cyc]   = iss && !rst;
      irw[cyc]  = rw;
      idst[cyc] = d;
      ires[cyc] = DW'(64'(a) * 64'(b));
      ik[cyc]   = 0;
      if (kill && cyc > 0) ik[cyc-1] = 1;
      @(negedge clk);
      check_outputs(rst);
      @(posedge clk);
      #1;
      if (rst) floor_c = cyc + 1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, 0, '0, '0, 0, 0);
   endtask

   initial begin
      #1;
      step(0, '0, 0, '0, '0, 0, 1);
      step(0, '0, 0, '0, '0, 0, 1);
      idle(2);
      // single op 7*6 -> r3
      step(1, 5'd3, 1, 32'd7, 32'd6, 0, 0);
      idle(7);
      // five back-to-back ops r1..r5
      for (int i = 1; i <= 5; i++) step(1, RA'(i), 1, DW'(i * 3 + 1), DW'(i + 10), 0, 0);
      idle(7);
      // corner operands
      step(1, 5'd10, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
      step(1, 5'd11, 1, 32'h00010000, 32'h00010000, 0, 0);
      step(1, 5'd12, 1, 32'h12345678, 32'h9ABCDEF0, 0, 0);
      idle(7);
      // write to r0 flows through but never writes
      step(1, 5'd0, 1, 32'd5, 32'd9, 0, 0);
      idle(7);
      // kill the op in M1 while a new op to r9 issues
      step(1, 5'd7, 1, 32'd100, 32'd3, 0, 0);
      step(1, 5'd9, 1, 32'd11, 32'd13, 1, 0);
      idle(7);
      // same-destination back-to-back, and a non-writing op
      step(1, 5'd4, 1, 32'd2, 32'd3, 0, 0);
      step(1, 5'd4, 1, 32'd4, 32'd5, 0, 0);
      step(1, 5'd6, 0, 32'd8, 32'd9, 0, 0);
      idle(7);
      // reset with three ops in flight
      step(1, 5'd1, 1, 32'd1, 32'd2, 0, 0);
      step(1, 5'd2, 1, 32'd3, 32'd4, 0, 0);
      step(1, 5'd3, 1, 32'd5, 32'd6, 0, 0);
      step(0, '0, 0, '0, '0, 0, 1);
      idle(7);
      // random traffic
      for (int i = 0; i < 400; i++) begin
         bit rst;
         rst = ($urandom_range(99) == 0);
         step(($urandom_range(3) != 0), RA'($urandom_range(31)), ($urandom_range(3) != 0),
              DW'($urandom), DW'($urandom), ($urandom_range(5) == 0), rst);
      end
      idle(7);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
